// File: rtl/serializer_10b.sv
// serializer_10b: 10-bit parallel-to-serial transmit stage, MSB (bit a) first.
// One-entry hold buffer ahead of the shifter; inserts IDLE_SYM when starved.
module serializer_10b #(
  parameter logic [9:0] IDLE_SYM = 10'b0011111010
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       tx_en,
  input  logic [9:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       data_out,
  output logic       data_out_valid,
  output logic       sym_start,
  output logic       idle_ins
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nx;
  logic [9:0] sreg, sreg_nx;
  logic [9:0] hold, hold_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic       hold_full, hold_full_nx;
  logic       dov_nx, start_nx, idle_nx;

  logic       at_end, load, shift, stop;
  logic       xfer, bypass, idle_sel;
  logic [9:0] sel;

  assign at_end = (bit_cnt == 4'd9);
  assign load   = tx_en & ((state == IDLE) | at_end);
  assign shift  = (state == RUN) & ~at_end;
  assign stop   = (state == RUN) & at_end & ~tx_en;

  assign xfer     = sym_valid & ~hold_full;
  assign bypass   = load & xfer;
  assign idle_sel = ~hold_full & ~sym_valid;
  assign sel      = hold_full ? hold :
                    sym_valid ? sym_in : IDLE_SYM;

  assign sym_ready = ~hold_full;
  assign data_out  = sreg[9];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (load)      state_nx = RUN;
    else if (stop) state_nx = IDLE;
  end

  always_comb begin
    sreg_nx      = sreg;
    bit_cnt_nx   = bit_cnt;
    dov_nx       = data_out_valid;
    start_nx     = 1'b0;
    idle_nx      = 1'b0;
    hold_nx      = hold;
    hold_full_nx = hold_full;
    unique case (1'b1)
      load: begin
        sreg_nx    = sel;
        bit_cnt_nx = 4'd0;
        dov_nx     = 1'b1;
        start_nx   = 1'b1;
        idle_nx    = idle_sel;
      end
      shift: begin
        sreg_nx    = {sreg[8:0], 1'b0};
        bit_cnt_nx = bit_cnt + 4'd1;
      end
      stop: begin
        sreg_nx    = '0;
        bit_cnt_nx = 4'd0;
        dov_nx     = 1'b0;
      end
      default: ;
    endcase
    // Hold drains only on a load; it fills on any non-bypass transfer.
    if (load & hold_full) begin
      hold_full_nx = 1'b0;
    end else if (xfer & ~bypass) begin
      hold_nx      = sym_in;
      hold_full_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sreg           <= '0;
      bit_cnt        <= '0;
      hold           <= '0;
      hold_full      <= 1'b0;
      data_out_valid <= 1'b0;
      sym_start      <= 1'b0;
      idle_ins       <= 1'b0;
    end else begin
      sreg           <= sreg_nx;
      bit_cnt        <= bit_cnt_nx;
      hold           <= hold_nx;
      hold_full      <= hold_full_nx;
      data_out_valid <= dov_nx;
      sym_start      <= start_nx;
      idle_ins       <= idle_nx;
    end
  end

endmodule

// File: tb/tb_serializer_10b.sv
// tb_serializer_10b: directed vectors for serializer_10b.
// Bit streams are compared against hand-written symbol constants.
module tb_serializer_10b;

  localparam logic [9:0] IDLE_SYM = 10'b0011111010;
  localparam logic [9:0] SYM_A = 10'b1010110001;
  localparam logic [9:0] SYM_B = 10'b1110001001;
  localparam logic [9:0] SYM_C = 10'b0110011100;
  localparam logic [9:0] SYM_D = 10'b1001110010;
  localparam logic [9:0] SYM_E = 10'b1100110101;
  localparam logic [9:0] SYM_F = 10'b0101010101;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       tx_en;
  logic [9:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       data_out;
  logic       data_out_valid;
  logic       sym_start;
  logic       idle_ins;

  logic [9:0] strm [8];
  int nvec = 0;
  int nerr = 0;
  int idx;
  int low;
  logic hs;
  logic [9:0] tmp;

  always #5 clk = ~clk;

  serializer_10b dut (
    .clk            (clk),
    .reset_L        (reset_L),
    .tx_en          (tx_en),
    .sym_in         (sym_in),
    .sym_valid      (sym_valid),
    .sym_ready      (sym_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .sym_start      (sym_start),
    .idle_ins       (idle_ins)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_L   = 1'b0;
    tx_en     = 1'b0;
    sym_valid = 1'b0;
    tick();
    reset_L = 1'b1;
  endtask

  task automatic expect_sym(input string tag,
                            input logic [9:0] s,
                            input logic idl,
                            input int novalid_at,
                            input int drop_at);
    for (int i = 0; i < 10; i++) begin
      check({tag, ".bit"}, data_out, s[9-i]);
      check({tag, ".dov"}, data_out_valid, 1);
      check({tag, ".start"}, sym_start, (i == 0));
      check({tag, ".idle"}, idle_ins, (i == 0) && idl);
      if (i == novalid_at) sym_valid = 1'b0;
      if (i == drop_at) tx_en = 1'b0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1);
  end

  initial begin
    strm[0] = 10'b1111000011; strm[1] = 10'b0000111101;
    strm[2] = 10'b1011001010; strm[3] = 10'b0100110101;
    strm[4] = 10'b1100011100; strm[5] = 10'b0011100011;
    strm[6] = 10'b1001001011; strm[7] = 10'b0110110100;

    reset_L = 1'b0; tx_en = 1'b0; sym_valid = 1'b0; sym_in = '0;
    #12;
    check("rst.data", data_out, 0);
    check("rst.dov", data_out_valid, 0);
    check("rst.start", sym_start, 0);
    check("rst.idle", idle_ins, 0);
    check("rst.ready", sym_ready, 1);
    tick();
    reset_L = 1'b1;
    tick();
    check("off.dov", data_out_valid, 0);
    check("off.data", data_out, 0);

    // single symbol via bypass, then idle insertion
    tx_en = 1'b1; sym_valid = 1'b1; sym_in = SYM_A;
    tick();
    expect_sym("single", SYM_A, 1'b0, 0, -1);
    expect_sym("idle1", IDLE_SYM, 1'b1, -1, -1);

    // back-to-back streaming of 8 symbols
    do_reset();
    tx_en = 1'b1; idx = 0; sym_valid = 1'b1; sym_in = strm[0];
    hs = sym_valid & sym_ready;
    tick();
    if (hs) begin idx++; sym_in = strm[idx]; end
    for (int k = 0; k < 8; k++) begin
      low = 0;
      for (int i = 0; i < 10; i++) begin
        tmp = strm[k];
        check("strm.bit", data_out, tmp[9-i]);
        check("strm.dov", data_out_valid, 1);
        check("strm.start", sym_start, (i == 0));
        check("strm.idle", idle_ins, 0);
        if (!sym_ready) low++;
        hs = sym_valid & sym_ready;
        tick();
        if (hs) begin
          idx++;
          if (idx < 8) sym_in = strm[idx];
          else sym_valid = 1'b0;
        end
      end
      check("strm.ready_low", low, (k < 7) ? 9 : 0);
    end
    check("strm.end_start", sym_start, 1);
    check("strm.end_idle", idle_ins, 1);

    // stop at boundary with a held symbol, then resume
    do_reset();
    tx_en = 1'b1; sym_valid = 1'b1; sym_in = SYM_B;
    tick();
    sym_in = SYM_C;
    expect_sym("stop", SYM_B, 1'b0, 1, 3);
    check("stop.dov", data_out_valid, 0);
    check("stop.data", data_out, 0);
    check("stop.start", sym_start, 0);
    check("stop.ready", sym_ready, 0);
    tick(); tick();
    check("stop.dov2", data_out_valid, 0);
    check("stop.ready2", sym_ready, 0);
    tx_en = 1'b1;
    tick();
    check("resume.ready", sym_ready, 1);
    expect_sym("resume", SYM_C, 1'b0, -1, -1);

    // late arrival after an idle load, with back-pressure churn
    low = 0;
    for (int i = 0; i < 10; i++) begin
      check("late.idle_bit", data_out, IDLE_SYM[9-i]);
      check("late.idle_flag", idle_ins, (i == 0));
      if (!sym_ready) low++;
      if (i == 0) begin
        sym_valid = 1'b1; sym_in = SYM_D;
      end else if (i == 9) begin
        sym_valid = 1'b0;
      end else begin
        sym_in = 10'h3C0 ^ 10'(i * 37);
      end
      tick();
    end
    check("late.ready_low", low, 9);
    expect_sym("late", SYM_D, 1'b0, -1, -1);
    expect_sym("after_late", IDLE_SYM, 1'b1, -1, -1);

    // asynchronous reset mid-symbol with hold full
    do_reset();
    tx_en = 1'b1; sym_valid = 1'b1; sym_in = SYM_E;
    tick();
    sym_in = SYM_F;
    check("mid.bit0", data_out, SYM_E[9]);
    tick();
    sym_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("mid.bit", data_out, SYM_E[9-i]);
      tick();
    end
    check("mid.ready_full", sym_ready, 0);
    check("mid.bit4", data_out, SYM_E[5]);
    #2;
    reset_L = 1'b0;
    #1;
    check("mid.rst_data", data_out, 0);
    check("mid.rst_dov", data_out_valid, 0);
    check("mid.rst_start", sym_start, 0);
    check("mid.rst_idle", idle_ins, 0);
    check("mid.rst_ready", sym_ready, 1);
    tick();
    reset_L = 1'b1;
    tick();
    expect_sym("recover", IDLE_SYM, 1'b1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
